// File: rtl/vs_bus_scheduler.sv
// rtl/vs_bus_scheduler.sv - VS1003 serial bus sequencer: reset/boot, SCI command and SDI stream arbitration
module vs_bus_scheduler #(
  parameter int          SCLK_DIV    = 2,
  parameter int          RESET_DELAY = 500000,
  parameter int          ADDR_W      = 12,
  parameter int          MAX_ADDR    = 4095,
  parameter logic [15:0] BOOT_MODE   = 16'h0804,
  parameter logic [15:0] BOOT_VOL    = 16'h0000
) (
  input  logic              mp3_clk,
  input  logic              RST,
  input  logic              DREQ,
  input  logic              play,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_addr,
  input  logic [15:0]       cmd_data,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_dout,
  output logic              XRESET,
  output logic              XCS,
  output logic              XDCS,
  output logic              SCLK,
  output logic              SI,
  output logic              busy
);

  localparam int HOLD_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  typedef enum logic [2:0] {HOLD, BOOT, IDLE, LOAD, SHIFT, GAP} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [4:0]          bit_q, bit_d;
  logic                gap_q, gap_d;
  logic [1:0]          boot_q, boot_d;    // 0/1 = boot frame in flight, 2 = boot done
  logic                sci_q, sci_d;      // current frame goes to SCI (XCS) rather than SDI
  logic [31:0]         shreg_q, shreg_d;
  logic                pend_q, pend_d;
  logic [7:0]          caddr_q, caddr_d;
  logic [15:0]         cdata_q, cdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sclk_q, sclk_d;
  logic                xcs_q, xcs_d;
  logic                xdcs_q, xdcs_d;
  logic                xreset_q, xreset_d;
  logic                cmd_take;
  logic [4:0]          last_bit;
  logic [31:0]         frame;

  assign cmd_ready = (state_q == IDLE) && !pend_q;
  assign cmd_take  = cmd_ready && cmd_valid;
  assign last_bit  = sci_q ? 5'd31 : 5'd15;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign XRESET    = xreset_q;
  assign XCS       = xcs_q;
  assign XDCS      = xdcs_q;
  assign SCLK      = sclk_q;
  assign SI        = shreg_q[31];

  // Pick the word that LOAD latches: boot frames, the captured command, or the BRAM word left-aligned
  always_comb begin
    frame = {mem_dout, 16'h0000};
    if (sci_q) begin
      case (boot_q)
        2'd0:    frame = {8'h02, 8'h00, BOOT_MODE};
        2'd1:    frame = {8'h02, 8'h0B, BOOT_VOL};
        default: frame = {8'h02, caddr_q, cdata_q};
      endcase
    end
  end

  // Next-state and datapath decisions; every register defaults to holding its value
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    boot_d   = boot_q;
    sci_d    = sci_q;
    shreg_d  = shreg_q;
    pend_d   = pend_q;
    caddr_d  = caddr_q;
    cdata_d  = cdata_q;
    addr_d   = addr_q;
    sclk_d   = sclk_q;
    xcs_d    = xcs_q;
    xdcs_d   = xdcs_q;
    xreset_d = xreset_q;
    case (state_q)
      HOLD: begin
        if (hold_q == HOLD_W'(RESET_DELAY - 1)) begin
          xreset_d = 1'b1;
          state_d  = BOOT;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      BOOT: begin
        if (DREQ) begin
          state_d = LOAD;
          sci_d   = 1'b1;
          xcs_d   = 1'b0;
        end
      end
      IDLE: begin
        if (cmd_take) begin
          pend_d  = 1'b1;
          caddr_d = cmd_addr;
          cdata_d = cmd_data;
        end
        // A command accepted this cycle already outranks streaming
        if ((pend_q || cmd_take) && DREQ) begin
          state_d = LOAD;
          sci_d   = 1'b1;
          xcs_d   = 1'b0;
        end else if (play && DREQ) begin
          state_d = LOAD;
          sci_d   = 1'b0;
          xdcs_d  = 1'b0;
        end
      end
      LOAD: begin
        shreg_d = frame;
        div_d   = '0;
        bit_d   = 5'd0;
        sclk_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q != DIV_W'(SCLK_DIV - 1)) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of the high phase: SI moves only together with SCLK falling
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[30:0], 1'b0};
            if (bit_q == last_bit) begin
              state_d = GAP;
              gap_d   = 1'b0;
              xcs_d   = 1'b1;
              xdcs_d  = 1'b1;
              if (!sci_q)
                addr_d = (addr_q == ADDR_W'(MAX_ADDR)) ? '0 : addr_q + ADDR_W'(1);
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end
      GAP: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else if (sci_q && boot_q != 2'd2) begin
          boot_d  = boot_q + 2'd1;
          state_d = (boot_q == 2'd1) ? IDLE : BOOT;
        end else begin
          state_d = IDLE;
          if (sci_q)
            pend_d = 1'b0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge mp3_clk) begin
    if (!RST) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      div_q    <= '0;
      bit_q    <= 5'd0;
      gap_q    <= 1'b0;
      boot_q   <= 2'd0;
      sci_q    <= 1'b0;
      shreg_q  <= 32'h0;
      pend_q   <= 1'b0;
      caddr_q  <= 8'h00;
      cdata_q  <= 16'h0000;
      addr_q   <= '0;
      sclk_q   <= 1'b0;
      xcs_q    <= 1'b1;
      xdcs_q   <= 1'b1;
      xreset_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      boot_q   <= boot_d;
      sci_q    <= sci_d;
      shreg_q  <= shreg_d;
      pend_q   <= pend_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
      addr_q   <= addr_d;
      sclk_q   <= sclk_d;
      xcs_q    <= xcs_d;
      xdcs_q   <= xdcs_d;
      xreset_q <= xreset_d;
    end
  end

endmodule

// File: tb/tb_vs_bus_scheduler.sv
// tb/tb_vs_bus_scheduler.sv - frame-level bench for vs_bus_scheduler
module tb_vs_bus_scheduler;

  localparam int SCLK_DIV = 1;
  localparam int ADDR_W   = 12;

  logic              mp3_clk = 1'b0;
  logic              RST = 1'b0;
  logic              DREQ = 1'b1;
  logic              play = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [7:0]        cmd_addr = 8'h00;
  logic [15:0]       cmd_data = 16'h0000;
  logic              cmd_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_dout;
  logic              XRESET, XCS, XDCS, SCLK, SI, busy;

  logic [15:0] bram [4];
  logic [48:0] sb [$];
  int n_vec = 0;
  int n_err = 0;

  vs_bus_scheduler #(
    .SCLK_DIV(SCLK_DIV), .RESET_DELAY(8), .ADDR_W(ADDR_W), .MAX_ADDR(3),
    .BOOT_MODE(16'h0804), .BOOT_VOL(16'h0000)
  ) dut (
    .mp3_clk(mp3_clk), .RST(RST), .DREQ(DREQ), .play(play),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .mem_addr(mem_addr), .mem_dout(mem_dout),
    .XRESET(XRESET), .XCS(XCS), .XDCS(XDCS), .SCLK(SCLK), .SI(SI), .busy(busy)
  );

  always #5 mp3_clk = ~mp3_clk;

  always @(posedge mp3_clk) mem_dout <= bram[mem_addr[1:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // record = {si_glitch, both_selects_low, sci, cs_low_cycles[7:0], bits[5:0], data[31:0]}
  task automatic push_exp(input logic sci, input logic [31:0] data);
    int nb;
    nb = sci ? 32 : 16;
    sb.push_back({2'b00, sci, 8'(1 + nb * 2 * SCLK_DIV), 6'(nb), data});
  endtask

  // Frame monitor: collects SI on each SCLK rise while a select is low
  logic        m_in = 1'b0, m_sci = 1'b0, m_both = 1'b0, m_glitch = 1'b0;
  logic        m_sclk_prev = 1'b0, m_si_prev = 1'b0;
  logic [31:0] m_sh = 32'h0;
  int          m_bits = 0, m_cyc = 0;
  logic [48:0] m_exp;
  always @(negedge mp3_clk) begin
    if (RST !== 1'b1) begin
      m_in = 1'b0;
    end else if (!XCS || !XDCS) begin
      if (!m_in) begin
        m_in = 1'b1; m_sci = !XCS; m_sh = 32'h0; m_bits = 0; m_cyc = 0;
        m_both = 1'b0; m_glitch = 1'b0;
      end
      if (!XCS && !XDCS) m_both = 1'b1;
      m_cyc++;
      if (SCLK && !m_sclk_prev) begin
        if (SI !== m_si_prev) m_glitch = 1'b1;
        m_sh = {m_sh[30:0], SI};
        m_bits++;
      end
    end else if (m_in) begin
      m_in = 1'b0;
      m_exp = (sb.size() > 0) ? sb.pop_front() : '1;
      chk(m_sci ? "sci_frame" : "sdi_frame",
          64'({m_glitch, m_both, m_sci, 8'(m_cyc), 6'(m_bits), m_sh}), 64'(m_exp));
    end
    m_sclk_prev = SCLK;
    m_si_prev = SI;
  end

  initial begin
    int cyc;
    int cs_seen;
    bram[0] = 16'hA5C3; bram[1] = 16'h1234; bram[2] = 16'h5A5A; bram[3] = 16'h0F0F;

    // Reset state
    repeat (2) @(negedge mp3_clk);
    chk("rst_xreset", 64'(XRESET), 64'd0);
    chk("rst_xcs", 64'(XCS), 64'd1);
    chk("rst_xdcs", 64'(XDCS), 64'd1);
    chk("rst_sclk", 64'(SCLK), 64'd0);
    chk("rst_si", 64'(SI), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);

    // Boot
    push_exp(1'b1, 32'h02000804);
    push_exp(1'b1, 32'h020B0000);
    RST = 1'b1;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge mp3_clk); cyc++; #1;
      if (XRESET) break;
    end
    chk("xreset_delay", 64'(cyc), 64'd8);
    for (int i = 0; i < 500 && busy !== 1'b0; i++) @(negedge mp3_clk);
    chk("boot_busy_low", 64'(busy), 64'd0);
    chk("boot_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("boot_frames_left", 64'(sb.size()), 64'd0);

    // Streaming two words
    push_exp(1'b0, 32'h0000A5C3);
    push_exp(1'b0, 32'h00001234);
    play = 1'b1;
    for (int i = 0; i < 500 && mem_addr !== 12'd2; i++) @(negedge mp3_clk);
    play = 1'b0;
    for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge mp3_clk);
    chk("stream_mem_addr", 64'(mem_addr), 64'd2);
    chk("stream_xcs", 64'(XCS), 64'd1);
    chk("stream_frames_left", 64'(sb.size()), 64'd0);

    // Arbitration mid-word, then wrap past MAX_ADDR
    push_exp(1'b0, 32'h00005A5A);
    push_exp(1'b1, 32'h020B2020);
    push_exp(1'b0, 32'h00000F0F);
    push_exp(1'b0, 32'h0000A5C3);
    play = 1'b1;
    for (int i = 0; i < 50 && XDCS !== 1'b0; i++) @(negedge mp3_clk);
    repeat (10) @(negedge mp3_clk);
    cmd_valid = 1'b1; cmd_addr = 8'h0B; cmd_data = 16'h2020;
    chk("arb_cmd_ready_low", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) @(negedge mp3_clk);
    chk("arb_cmd_ready_high", 64'(cmd_ready), 64'd1);
    @(negedge mp3_clk);
    cmd_valid = 1'b0;
    chk("arb_sci_first", 64'({XCS, XDCS}), 64'b01);
    for (int i = 0; i < 500 && mem_addr !== 12'd0; i++) @(negedge mp3_clk);
    chk("wrap_mem_addr", 64'(mem_addr), 64'd0);
    for (int i = 0; i < 200 && mem_addr !== 12'd1; i++) @(negedge mp3_clk);
    play = 1'b0;
    for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge mp3_clk);
    chk("arb_frames_left", 64'(sb.size()), 64'd0);

    // DREQ gating with a pending command and play
    DREQ = 1'b0; play = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 8'h05; cmd_data = 16'hBEEF;
    @(negedge mp3_clk);
    cmd_valid = 1'b0;
    chk("dreq_cmd_pending", 64'(cmd_ready), 64'd0);
    cs_seen = 0;
    repeat (20) begin
      @(negedge mp3_clk);
      if (!XCS || !XDCS) cs_seen++;
    end
    chk("dreq_no_select", 64'(cs_seen), 64'd0);
    chk("dreq_idle", 64'(busy), 64'd0);
    push_exp(1'b1, 32'h0205BEEF);
    push_exp(1'b0, 32'h00001234);
    DREQ = 1'b1;
    @(negedge mp3_clk);
    chk("dreq_start_sci", 64'({XCS, XDCS}), 64'b01);
    repeat (10) @(negedge mp3_clk);
    DREQ = 1'b0;
    for (int i = 0; i < 200 && XCS !== 1'b1; i++) @(negedge mp3_clk);
    repeat (10) @(negedge mp3_clk);
    chk("dreq_hold_sdi", 64'({busy, XDCS}), 64'b01);
    DREQ = 1'b1;
    for (int i = 0; i < 200 && mem_addr !== 12'd2; i++) @(negedge mp3_clk);
    play = 1'b0;
    for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge mp3_clk);
    chk("dreq_frames_left", 64'(sb.size()), 64'd0);

    // Reset during SHIFT, then full boot replay
    play = 1'b1;
    for (int i = 0; i < 50 && XDCS !== 1'b0; i++) @(negedge mp3_clk);
    repeat (5) @(negedge mp3_clk);
    RST = 1'b0; play = 1'b0;
    @(negedge mp3_clk);
    chk("mid_rst_outputs", 64'({XCS, XDCS, SCLK, XRESET}), 64'b1100);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(negedge mp3_clk);
    push_exp(1'b1, 32'h02000804);
    push_exp(1'b1, 32'h020B0000);
    RST = 1'b1;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge mp3_clk); cyc++; #1;
      if (XRESET) break;
    end
    chk("replay_xreset_delay", 64'(cyc), 64'd8);
    for (int i = 0; i < 500 && busy !== 1'b0; i++) @(negedge mp3_clk);
    chk("replay_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("replay_frames_left", 64'(sb.size()), 64'd0);
    chk("replay_mem_addr", 64'(mem_addr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vs_bus_scheduler.md
# vs_bus_scheduler

Sequencer and arbiter for the single serial bus to the VS1003 MP3 decoder. It performs the hardware reset and boot register writes, then shares the bus between runtime SCI register writes (volume and similar) and SDI audio streaming from the music block RAM. Every transfer is gated by DREQ. It sits between the board-level control logic, the audio BRAM and the decoder pins, and is clocked by the divided mp3_clk.

## Interface
- SCLK_DIV, 2: mp3_clk cycles per SCLK half-period (≥1)
- RESET_DELAY, 500000: mp3_clk cycles XRESET is held low after reset
- ADDR_W, 12: BRAM address width
- MAX_ADDR, 4095: last valid audio word address; wraps to 0 after it
- BOOT_MODE, 16'h0804: data written to SCI reg 0x00 at boot
- BOOT_VOL, 16'h0000: data written to SCI reg 0x0B at boot

Ports:
- mp3_clk  in  1  clock
- RST  in  1  reset, synchronous, active-low
- DREQ  in  1  decoder ready for data/command
- play  in  1  1 = stream audio words
- cmd_valid  in  1  runtime SCI write request
- cmd_addr  in  8  SCI register address
- cmd_data  in  16  SCI register data
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready
- mem_addr  out  ADDR_W  BRAM read address
- mem_dout  in  16  BRAM data, 1-cycle read latency
- XRESET  out  1  decoder hardware reset, active-low
- XCS  out  1  SCI chip select, active-low
- XDCS  out  1  SDI chip select, active-low
- SCLK  out  1  serial clock
- SI  out  1  serial data, MSB first
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: HOLD, BOOT, IDLE, LOAD, SHIFT, GAP.
- HOLD: XRESET=0; counter runs for RESET_DELAY cycles, then XRESET=1 and go to BOOT.
- BOOT: queues two SCI frames, {8'h02, 8'h00, BOOT_MODE} then {8'h02, 8'h0B, BOOT_VOL}. Each is issued via LOAD/SHIFT/GAP when DREQ=1. After the second frame's GAP, go to IDLE.
- IDLE, in priority order:
  - A pending command with DREQ=1 starts an SCI frame {8'h02, cmd_addr, cmd_data}.
  - Otherwise play=1 with DREQ=1 starts an SDI word from mem_dout.
  - Otherwise stay in IDLE.
- cmd_ready=1 only in IDLE with no pending command. On acceptance, addr and data are captured. The command stays pending until its frame completes. It waits for DREQ and always beats data.
- LOAD (1 cycle): latch the shift register (32 bits for SCI, 16 for SDI). Assert XCS or XDCS low (never both). SCLK=0.
- SHIFT, per bit: SI = shift-register MSB, driven for SCLK_DIV cycles with SCLK=0, then SCLK_DIV cycles with SCLK=1. Shift left at the end of the high phase.
- DREQ is not sampled during LOAD/SHIFT/GAP; a started frame always completes.
- After the last bit's high phase: SCLK=0, chip select deasserts, and the SDI case increments mem_addr (MAX_ADDR→0). Go to GAP.
- GAP: 2 cycles with both selects high, then IDLE. mem_dout for the new address is valid by the next IDLE.
- play falling mid-word: finish the word, then stop streaming; mem_addr holds. play rising resumes from the held mem_addr.
- Reset mid-operation: all outputs take their reset values at the next edge. The sequence restarts from HOLD, including the XRESET pulse and boot frames. Any pending command is dropped.

## Timing
- Reset values: XRESET=0, XCS=1, XDCS=1, SCLK=0, SI=0, mem_addr=0, cmd_ready=0, busy=1.
- Boot timing: XRESET rises exactly RESET_DELAY cycles after RST is released.
- SCI frame: LOAD 1 + 32·2·SCLK_DIV + GAP 2 cycles. With SCLK_DIV=2 that is 131 cycles.
- SDI word: 1 + 16·2·SCLK_DIV + 2 cycles. With SCLK_DIV=2 that is 67 cycles.
- Start latency: a transfer starts the cycle after IDLE sees DREQ=1.
- SI is stable across each SCLK rising edge; it changes only while SCLK=0.
- XCS low spans LOAD through the last high phase inclusive; XDCS behaves the same way for SDI.

## Test plan
- Boot, with RESET_DELAY=8, SCLK_DIV=1, DREQ=1:
  - XRESET rises 8 cycles after release.
  - SI on XCS-low rising edges reads 0x02000804, then 0x020B0000.
  - busy falls; cmd_ready=1.
- Streaming, with BRAM word0=0xA5C3, word1=0x1234 and play=1:
  - Two XDCS frames shift 0xA5C3 then 0x1234.
  - mem_addr reads 2 afterwards; XCS stays 1.
- Arbitration:
  - Issue cmd (0x0B, 0x2020) mid-SDI-word.
  - cmd_ready drops; the word completes.
  - The next frame is SCI 0x020B2020, then streaming resumes.
- DREQ gating: hold DREQ=0 with a command pending and play=1.
  - No chip select asserts; the command stays pending.
  - When DREQ rises, the SCI frame goes first.
  - A DREQ drop mid-frame does not truncate the frame.
- Wrap, with MAX_ADDR=3: after 4 words mem_addr=0 and the fifth word equals word0.
- Mid-transfer reset: drop RST during SHIFT.
  - The next edge gives XCS=XDCS=1, SCLK=0, XRESET=0, mem_addr=0.
  - Boot replays in full.
